// File: rtl/two_port_mux_arbiter_if.sv
// Bundle of the producer-side, grant/select and consumer-side signals of the
// two-port mux arbiter. The arbiter uses the slave view; the surrounding
// producers/consumer (or a bench) use the master view.
interface two_port_mux_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  last_a;
  logic                  ack_a;
  logic                  req_b;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  last_b;
  logic                  ack_b;
  logic                  grant_a;
  logic                  grant_b;
  logic                  mux_sel;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport slave (
    input  req_a, data_a, last_a, req_b, data_b, last_b, out_ready,
    output ack_a, ack_b, grant_a, grant_b, mux_sel, out_valid, out_data
  );

  modport master (
    output req_a, data_a, last_a, req_b, data_b, last_b, out_ready,
    input  ack_a, ack_b, grant_a, grant_b, mux_sel, out_valid, out_data
  );
endinterface

// File: rtl/two_port_mux_arbiter.sv
// Round-robin burst arbiter sharing one 2:1 mux datapath between requesters
// A (port 0) and B (port 1), with a registered valid/ready output slot.

// Plain 2:1 mux; sel=0 picks port 0 (A), sel=1 picks port 1 (B).
module tpma_mux2 #(
  parameter int W = 8
) (
  input  logic             sel,
  input  logic [1:0][W-1:0] din,
  output logic [W-1:0]     dout
);
  assign dout = sel ? din[1] : din[0];
endmodule

// Per-port handshake qualification: accept, burst-ending beat, abandon.
module tpma_port (
  input  logic grant,
  input  logic req,
  input  logic last,
  input  logic slot_free,
  input  logic cnt_hit,
  output logic ack,
  output logic beat_end,
  output logic abandon
);
  assign ack      = grant & req & slot_free;
  assign beat_end = ack & (last | cnt_hit);
  assign abandon  = grant & ~req;
endmodule

module two_port_mux_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  parameter int CNT_W      = 3
) (
  input logic                     clk,
  input logic                     reset_n,
  two_port_mux_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  state_t                      state, nxt_state;
  logic                        grant_a_q, grant_b_q, sel_q, rr_q;
  logic [CNT_W-1:0]            cnt, cnt_inc;
  logic                        out_valid_q;
  logic [DATA_WIDTH-1:0]       out_data_q, mux_out;

  logic [1:0]                  req, last, gnt, ack, beat_end, abandon;
  logic [1:0][DATA_WIDTH-1:0]  data;
  logic                        slot_free, cnt_hit, accept, burst_end, was_abandon;
  logic                        owner, other;

  assign req  = {bus.req_b,  bus.req_a};
  assign last = {bus.last_b, bus.last_a};
  assign data = {bus.data_b, bus.data_a};
  assign gnt  = {grant_b_q,  grant_a_q};

  assign slot_free = ~out_valid_q | bus.out_ready;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign cnt_hit   = (cnt_inc == BURST_LIM);

  for (genvar p = 0; p < 2; p++) begin : g_port
    tpma_port u_port (
      .grant     (gnt[p]),
      .req       (req[p]),
      .last      (last[p]),
      .slot_free (slot_free),
      .cnt_hit   (cnt_hit),
      .ack       (ack[p]),
      .beat_end  (beat_end[p]),
      .abandon   (abandon[p])
    );
  end

  tpma_mux2 #(.W(DATA_WIDTH)) u_mux (
    .sel  (sel_q),
    .din  (data),
    .dout (mux_out)
  );

  assign accept      = |ack;
  assign was_abandon = |abandon;
  assign burst_end   = |beat_end | was_abandon;
  assign owner       = (state == SERVE_B);
  assign other       = ~owner;

  // Next owner: idle pick by rr on contention; on burst end prefer the other
  // side, fall back to the same side only if it did not abandon.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: begin
        if (req[0] && req[1]) nxt_state = rr_q ? SERVE_B : SERVE_A;
        else if (req[0])      nxt_state = SERVE_A;
        else if (req[1])      nxt_state = SERVE_B;
      end
      default: begin
        if (burst_end) begin
          if (req[other])                      nxt_state = other ? SERVE_B : SERVE_A;
          else if (req[owner] && !was_abandon) nxt_state = owner ? SERVE_B : SERVE_A;
          else                                 nxt_state = IDLE;
        end
      end
    endcase
  end

  // FSM with registered grants/select; mux_sel follows the new owner on the
  // same edge so a handoff has no bubble, and holds while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      sel_q     <= 1'b0;
      rr_q      <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= nxt_state;
      grant_a_q <= (nxt_state == SERVE_A);
      grant_b_q <= (nxt_state == SERVE_B);
      if (nxt_state == SERVE_B)      sel_q <= 1'b1;
      else if (nxt_state == SERVE_A) sel_q <= 1'b0;
      if (burst_end) begin
        cnt  <= '0;
        rr_q <= other;
      end else if (accept) begin
        cnt  <= cnt_inc;
      end
    end
  end

  // Output slot: load on accept, drop valid when drained with nothing new.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_out;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.ack_a     = ack[0];
  assign bus.ack_b     = ack[1];
  assign bus.grant_a   = grant_a_q;
  assign bus.grant_b   = grant_b_q;
  assign bus.mux_sel   = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_two_port_mux_arbiter.sv
// Directed bench for two_port_mux_arbiter: a cycle table for single-beat,
// abandon and alternation behaviour, plus hand sequences for round-robin
// bursts, backpressure and asynchronous reset.
module tb_two_port_mux_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  two_port_mux_arbiter_if #(.DATA_WIDTH(8)) bus ();

  two_port_mux_arbiter #(.DATA_WIDTH(8), .BURST_MAX(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ra, la; logic [7:0] da;
    logic       rb, lb; logic [7:0] db;
    logic       rdy;
    logic       ea, eb, ga, gb, sel, ov; logic [7:0] od;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(logic ra, logic la, logic [7:0] da,
                              logic rb, logic lb, logic [7:0] db, logic rdy,
                              logic ea, logic eb, logic ga, logic gb,
                              logic sel, logic ov, logic [7:0] od);
    vec_t v;
    v.ra = ra; v.la = la; v.da = da; v.rb = rb; v.lb = lb; v.db = db; v.rdy = rdy;
    v.ea = ea; v.eb = eb; v.ga = ga; v.gb = gb; v.sel = sel; v.ov = ov; v.od = od;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ea, input logic eb,
                         input logic ga, input logic gb, input logic sel,
                         input logic ov, input logic [7:0] od);
    chk({tag, " ack_a"},     8'(bus.ack_a),     8'(ea));
    chk({tag, " ack_b"},     8'(bus.ack_b),     8'(eb));
    chk({tag, " grant_a"},   8'(bus.grant_a),   8'(ga));
    chk({tag, " grant_b"},   8'(bus.grant_b),   8'(gb));
    chk({tag, " mux_sel"},   8'(bus.mux_sel),   8'(sel));
    chk({tag, " out_valid"}, 8'(bus.out_valid), 8'(ov));
    chk({tag, " out_data"},  bus.out_data,      od);
  endtask

  task automatic drive(input logic ra, input logic la, input logic [7:0] da,
                       input logic rb, input logic lb, input logic [7:0] db,
                       input logic rdy);
    bus.req_a = ra; bus.last_a = la; bus.data_a = da;
    bus.req_b = rb; bus.last_b = lb; bus.data_b = db;
    bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1);

    //          ra la da     rb lb db     rdy  ea eb ga gb sl ov od
    tv[0]  = mk(1, 0, 8'h11, 0, 0, 8'h00, 1,   0, 0, 0, 0, 0, 0, 8'h00);
    tv[1]  = mk(1, 0, 8'h11, 0, 0, 8'h00, 1,   1, 0, 1, 0, 0, 0, 8'h00);
    tv[2]  = mk(1, 0, 8'h22, 0, 0, 8'h00, 1,   1, 0, 1, 0, 0, 1, 8'h11);
    tv[3]  = mk(1, 1, 8'h33, 0, 0, 8'h00, 1,   1, 0, 1, 0, 0, 1, 8'h22);
    tv[4]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,   0, 0, 1, 0, 0, 1, 8'h33);
    tv[5]  = mk(1, 0, 8'h44, 0, 0, 8'h00, 1,   0, 0, 0, 0, 0, 0, 8'h33);
    tv[6]  = mk(1, 0, 8'h44, 1, 0, 8'hB1, 1,   1, 0, 1, 0, 0, 0, 8'h33);
    tv[7]  = mk(0, 0, 8'h00, 1, 0, 8'hB1, 1,   0, 0, 1, 0, 0, 1, 8'h44);
    tv[8]  = mk(0, 0, 8'h00, 1, 1, 8'hB1, 1,   0, 1, 0, 1, 1, 0, 8'h44);
    tv[9]  = mk(1, 1, 8'hA1, 1, 1, 8'hB2, 1,   0, 1, 0, 1, 1, 1, 8'hB1);
    tv[10] = mk(1, 1, 8'hA1, 1, 1, 8'hB3, 1,   1, 0, 1, 0, 0, 1, 8'hB2);
    tv[11] = mk(1, 1, 8'hA2, 1, 1, 8'hB3, 1,   0, 1, 0, 1, 1, 1, 8'hA1);
    tv[12] = mk(1, 1, 8'hA2, 1, 1, 8'hB4, 1,   1, 0, 1, 0, 0, 1, 8'hB3);
    tv[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,   0, 0, 0, 1, 1, 1, 8'hA2);
    tv[14] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,   0, 0, 0, 0, 1, 0, 8'hA2);

    // Reset state
    do_reset();
    #1 chk_all("reset", 0, 0, 0, 0, 0, 0, 8'h00);

    // Table: single burst, abandon handoff, single-beat alternation
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tv[i].ra, tv[i].la, tv[i].da, tv[i].rb, tv[i].lb, tv[i].db, tv[i].rdy);
      #1 chk_all($sformatf("tbl c%0d", i), tv[i].ea, tv[i].eb, tv[i].ga,
                 tv[i].gb, tv[i].sel, tv[i].ov, tv[i].od);
    end

    // Both requesting continuously: 4-beat bursts alternating A/B
    do_reset();
    for (int c = 0; c < 18; c++) begin
      logic       s, sp;
      logic [7:0] eod;
      @(negedge clk);
      drive(1, 0, 8'(c), 1, 0, 8'h80 | 8'(c), 1);
      #1;
      if (c == 0) begin
        chk_all("rr c0", 0, 0, 0, 0, 0, 0, 8'h00);
      end else begin
        s   = 1'(((c - 1) / 4) % 2);
        sp  = 1'(((c - 2) / 4) % 2);
        eod = (c < 2) ? 8'h00 : (sp ? (8'h80 | 8'(c - 1)) : 8'(c - 1));
        chk_all($sformatf("rr c%0d", c), ~s, s, ~s, s, s, (c >= 2), eod);
      end
    end

    // B burst stalled by out_ready low for 3 cycles
    do_reset();
    @(negedge clk); drive(0, 0, 8'h00, 1, 0, 8'h51, 1);
    #1 chk_all("bp c0", 0, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk); drive(0, 0, 8'h00, 1, 0, 8'h51, 1);
    #1 chk_all("bp c1", 0, 1, 0, 1, 1, 0, 8'h00);
    for (int c = 2; c < 5; c++) begin
      @(negedge clk); drive(0, 0, 8'h00, 1, 0, 8'h52, 0);
      #1 chk_all($sformatf("bp c%0d", c), 0, 0, 0, 1, 1, 1, 8'h51);
    end
    @(negedge clk); drive(1, 0, 8'hAA, 1, 0, 8'h52, 1);
    #1 chk_all("bp c5", 0, 1, 0, 1, 1, 1, 8'h51);
    @(negedge clk); drive(1, 0, 8'hAA, 1, 0, 8'h53, 1);
    #1 chk_all("bp c6", 0, 1, 0, 1, 1, 1, 8'h52);
    @(negedge clk); drive(1, 0, 8'hAA, 1, 0, 8'h54, 1);
    #1 chk_all("bp c7", 0, 1, 0, 1, 1, 1, 8'h53);
    @(negedge clk); drive(1, 0, 8'hAA, 1, 0, 8'h55, 1);
    #1 chk_all("bp c8", 1, 0, 1, 0, 0, 1, 8'h54);

    // Asynchronous reset mid-burst, then rr favours A
    do_reset();
    @(negedge clk); drive(0, 0, 8'h00, 1, 0, 8'h61, 1);
    @(negedge clk); drive(0, 0, 8'h00, 1, 0, 8'h61, 1);
    @(negedge clk); drive(0, 0, 8'h00, 1, 0, 8'h62, 1);
    #1 chk_all("ar pre", 0, 1, 0, 1, 1, 1, 8'h61);
    #1 reset_n = 1'b0;
    #1 chk_all("ar async", 0, 0, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 8'h71, 1, 0, 8'h81, 1);
    @(negedge clk); reset_n = 1'b1;
    #1 chk_all("ar idle", 0, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    #1 chk_all("ar pick", 1, 0, 1, 0, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/two_port_mux_arbiter.md
Name: two_port_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit 2:1 mux datapath between two requesters (A and B).
- Drives the mux select, grants bursts of beats to one requester at a time, and registers the mux output behind a valid/ready handshake toward the consumer.
- Sits between two producer ports and a single downstream consumer. The 8-bit 2:1 mux is instantiated inside this block with select driven by mux_sel.

Parameters:
- DATA_WIDTH, 8, beat width; must equal the mux width.
- BURST_MAX, 4, maximum beats per grant before forced re-arbitration (range 1..7).
- CNT_W, 3, width of the beat counter; must satisfy 2^CNT_W > BURST_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A has a beat on data_a.
- data_a  input  DATA_WIDTH  requester A beat.
- last_a  input  1  current A beat ends A's burst.
- ack_a  output  1  A beat accepted this cycle (combinational).
- req_b, data_b, last_b, ack_b: same as A, for requester B.
- grant_a  output  1  A owns the datapath (registered).
- grant_b  output  1  B owns the datapath (registered).
- mux_sel  output  1  mux select; 0 = A, 1 = B (registered).
- out_valid  output  1  out_data holds a beat.
- out_data  output  DATA_WIDTH  registered mux output.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE; grant_a=grant_b=0; mux_sel=0; out_valid=0; out_data=0; beat counter=0; rr pointer=A.
  - Any beat held in the output register is discarded.
- States: IDLE, SERVE_A, SERVE_B. grant_a=(state==SERVE_A); grant_b=(state==SERVE_B). At most one grant is high at any time.
- IDLE:
  - Only req_a -> SERVE_A; only req_b -> SERVE_B.
  - Both -> the side indicated by the rr pointer.
  - Neither -> stay in IDLE.
  - mux_sel is loaded with the chosen side on the same edge. In IDLE it holds its last value.
- Output slot is free when !out_valid || out_ready.
- Accept (shown for A; B is symmetric): ack_a = grant_a && req_a && slot free.
  - On accept: out_data <= mux(data_a, data_b, mux_sel); out_valid <= 1; counter increments.
  - When the slot drains with no accept: out_valid <= 0, and out_data holds its value.
- Burst end for the owner X occurs on any of:
  - an accepted beat with last_X=1;
  - an accepted beat that brings the counter to BURST_MAX;
  - req_X low while granted (abandon; no beat is accepted).
- On burst end:
  - Counter clears; rr pointer points to the other side.
  - Next state: the other side if its req is high; else the same side if its req is still high and the end was not an abandon; else IDLE.
  - mux_sel updates on the same edge, so a switch costs no idle cycle.
- Latency:
  - Request in IDLE at cycle N -> grant and mux_sel valid at N+1.
  - First ack at N+1 if the slot is free.
  - out_valid at N+2.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- Backpressure: with out_ready=0 and out_valid=1, no ack is issued, and out_data and the counter are stable. Grant is held unless the owner abandons.
- Simultaneous events:
  - A last beat accepted together with a drain is a legal single-cycle handoff.
  - The owner's req dropping in the same cycle as an accept is impossible, because an accept requires req.

Test Plan:
1. Reset, then req_a=1 with data_a=8'h11, 8'h22, 8'h33 and last_a on the third beat, out_ready=1 -> grant_a at cycle 1; out_data sequence 11, 22, 33 on cycles 2-4; then IDLE with mux_sel=0.
2. req_a and req_b both high from reset, continuous, no last, BURST_MAX=4, out_ready=1 -> 4 A beats, then 4 B beats, alternating; mux_sel toggles every 4 accepts with no bubble.
3. B burst in progress with out_ready held low 3 cycles -> ack_b=0 and out_data stable for 3 cycles; grant_b stays 1; the stream resumes without loss or duplication.
4. grant_a active, req_a drops after 1 beat while req_b=1 -> next cycle grant_b=1 and mux_sel=1; the A counter is cleared.
5. reset_n pulsed low mid-burst with out_valid=1 -> all outputs return to reset values immediately, without waiting for a clock edge; after release the rr pointer favours A.
6. Alternate single-beat bursts (last=1) from A and B, both requesting every cycle -> out_data strictly alternates A, B, A, B at one beat per cycle.
